// File: rtl/uart_tx_scheduler_if.sv
// Measurement-in / serializer-control-out bundle for the UART packet scheduler.
// The master drives frame_valid and measurements; the slave (scheduler) drives timing and snapshot.
interface uart_tx_scheduler_if;
    logic        frame_valid;
    logic [11:0] centre_pos_x_in;
    logic [11:0] centre_pos_y_in;
    logic [9:0]  angle_x_in;
    logic [9:0]  angle_y_in;
    logic        chieu_xoay_in;

    logic        baud_clk;
    logic        tx_int;
    logic [11:0] centre_pos_x;
    logic [11:0] centre_pos_y;
    logic [9:0]  angle_x;
    logic [9:0]  angle_y;
    logic        chieu_xoay;
    logic        busy;
    logic [15:0] frames_sent;
    logic [7:0]  overwrite_cnt;

    modport master (
        output frame_valid, centre_pos_x_in, centre_pos_y_in, angle_x_in, angle_y_in, chieu_xoay_in,
        input  baud_clk, tx_int, centre_pos_x, centre_pos_y, angle_x, angle_y, chieu_xoay,
        input  busy, frames_sent, overwrite_cnt
    );

    modport slave (
        input  frame_valid, centre_pos_x_in, centre_pos_y_in, angle_x_in, angle_y_in, chieu_xoay_in,
        output baud_clk, tx_int, centre_pos_x, centre_pos_y, angle_x, angle_y, chieu_xoay,
        output busy, frames_sent, overwrite_cnt
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Paces measurement snapshots into fixed-length serializer windows, one-deep pending buffer, heartbeat resend.
// tx_int rises on the baud fall edge after LOAD; no backpressure -- newer measurements overwrite pending ones.
module uart_tx_scheduler #(
    parameter int CLK_DIV_HALF   = 2604,
    parameter int FRAME_BITS     = 122,
    parameter int GAP_BITS       = 2,
    parameter int HEARTBEAT_BITS = 9600
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_tx_scheduler_if.slave sif
);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int GW = $clog2(GAP_BITS + 1);
    localparam int HW = $clog2(HEARTBEAT_BITS + 1);

    localparam logic [11:0]   DIV_TC   = 12'(CLK_DIV_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);
    localparam logic [HW-1:0] HB_LAST  = HW'(HEARTBEAT_BITS - 1);

    typedef struct packed {
        logic [11:0] pos_x;
        logic [11:0] pos_y;
        logic [9:0]  ang_x;
        logic [9:0]  ang_y;
        logic        dir;
    } meas_t;

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

    state_t        state_q, state_d;
    logic [11:0]   div_cnt_q, div_cnt_d;
    logic          baud_clk_q, baud_clk_d;
    logic          tx_int_q, tx_int_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [HW-1:0] hb_cnt_q, hb_cnt_d;
    logic          pend_q, pend_d;
    logic          copied_q, copied_d;
    meas_t         pending_q, pending_d;
    meas_t         snap_q, snap_d;
    logic [15:0]   frames_sent_q, frames_sent_d;
    logic [7:0]    overwrite_cnt_q, overwrite_cnt_d;

    meas_t meas_in;
    logic  div_tc, fall_ev, bit_last, gap_last, hb_hit, load_copy, busy;

    assign meas_in  = {sif.centre_pos_x_in, sif.centre_pos_y_in, sif.angle_x_in,
                       sif.angle_y_in, sif.chieu_xoay_in};
    assign div_tc   = (div_cnt_q == DIV_TC);
    assign fall_ev  = div_tc & baud_clk_q;
    assign bit_last = (bit_cnt_q == BIT_LAST);
    assign gap_last = (gap_cnt_q == GAP_LAST);
    assign hb_hit   = (hb_cnt_q == HB_LAST);

    // Pending data is taken once per LOAD visit; a later arrival in the same LOAD waits for the next packet.
    assign load_copy = (state_q == LOAD) && pend_q && !copied_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pend_q || hb_hit)       state_d = LOAD;
            LOAD:    if (fall_ev)                state_d = SEND;
            SEND:    if (fall_ev && bit_last)    state_d = GAP;
            GAP:     if (fall_ev && gap_last)    state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    always_comb begin
        div_cnt_d       = div_tc ? 12'd0 : div_cnt_q + 12'd1;
        baud_clk_d      = baud_clk_q ^ div_tc;
        busy            = (state_q != IDLE);

        tx_int_d        = tx_int_q;
        bit_cnt_d       = bit_cnt_q;
        gap_cnt_d       = gap_cnt_q;
        frames_sent_d   = frames_sent_q;
        if (state_q == LOAD && fall_ev) begin
            tx_int_d      = 1'b1;
            bit_cnt_d     = '0;
            frames_sent_d = frames_sent_q + 16'd1;
        end
        if (state_q == SEND && fall_ev) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_last) begin
                tx_int_d  = 1'b0;
                gap_cnt_d = '0;
            end
        end
        if (state_q == GAP && fall_ev) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end

        // Counting only in IDLE; holding at zero elsewhere gives a clean start on every IDLE entry.
        hb_cnt_d = hb_cnt_q;
        if (sif.frame_valid || state_q != IDLE) begin
            hb_cnt_d = '0;
        end else if (fall_ev) begin
            hb_cnt_d = hb_cnt_q + 1'b1;
        end

        pend_d          = pend_q;
        pending_d       = pending_q;
        overwrite_cnt_d = overwrite_cnt_q;
        if (load_copy) begin
            pend_d = 1'b0;
        end
        if (sif.frame_valid) begin
            pending_d = meas_in;
            pend_d    = 1'b1;
            if (pend_q && !load_copy && overwrite_cnt_q != 8'hFF) begin
                overwrite_cnt_d = overwrite_cnt_q + 8'd1;
            end
        end

        snap_d   = load_copy ? pending_q : snap_q;
        copied_d = (state_q == LOAD) && (copied_q || load_copy);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q       <= '0;
            baud_clk_q      <= 1'b0;
            tx_int_q        <= 1'b0;
            bit_cnt_q       <= '0;
            gap_cnt_q       <= '0;
            hb_cnt_q        <= '0;
            pend_q          <= 1'b0;
            copied_q        <= 1'b0;
            pending_q       <= '0;
            snap_q          <= '0;
            frames_sent_q   <= '0;
            overwrite_cnt_q <= '0;
        end else begin
            div_cnt_q       <= div_cnt_d;
            baud_clk_q      <= baud_clk_d;
            tx_int_q        <= tx_int_d;
            bit_cnt_q       <= bit_cnt_d;
            gap_cnt_q       <= gap_cnt_d;
            hb_cnt_q        <= hb_cnt_d;
            pend_q          <= pend_d;
            copied_q        <= copied_d;
            pending_q       <= pending_d;
            snap_q          <= snap_d;
            frames_sent_q   <= frames_sent_d;
            overwrite_cnt_q <= overwrite_cnt_d;
        end
    end

    assign sif.baud_clk      = baud_clk_q;
    assign sif.tx_int        = tx_int_q;
    assign sif.centre_pos_x  = snap_q.pos_x;
    assign sif.centre_pos_y  = snap_q.pos_y;
    assign sif.angle_x       = snap_q.ang_x;
    assign sif.angle_y       = snap_q.ang_y;
    assign sif.chieu_xoay    = snap_q.dir;
    assign sif.busy          = busy;
    assign sif.frames_sent   = frames_sent_q;
    assign sif.overwrite_cnt = overwrite_cnt_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: expected packets queued at stimulus time, checked at each tx_int window.
module tb_uart_tx_scheduler;
    localparam int DIV    = 4;
    localparam int FRAMES = 122;
    localparam int HB     = 300;
    localparam int BAUD   = 2 * DIV;

    typedef struct {
        logic [44:0] snap;
        logic [15:0] fs;
        bit          hb;
        bit          abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if u_if ();

    uart_tx_scheduler #(
        .CLK_DIV_HALF  (DIV),
        .FRAME_BITS    (FRAMES),
        .GAP_BITS      (2),
        .HEARTBEAT_BITS(HB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sif  (u_if.slave)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t cur;
    int   pkts_started = 0;
    int   pkts_done = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [44:0] mk(input logic [11:0] x);
        return {x, x ^ 12'hA5A, x[9:0] ^ 10'h155, ~x[9:0], x[0]};
    endfunction

    function automatic logic [44:0] dut_snap();
        return {u_if.centre_pos_x, u_if.centre_pos_y, u_if.angle_x, u_if.angle_y, u_if.chieu_xoay};
    endfunction

    task automatic drive_frame(input logic [44:0] s);
        {u_if.centre_pos_x_in, u_if.centre_pos_y_in, u_if.angle_x_in,
         u_if.angle_y_in, u_if.chieu_xoay_in} = s;
        u_if.frame_valid = 1'b1;
        @(negedge clk);
        u_if.frame_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [44:0] s, input logic [15:0] fs, input bit hb, input bit abort);
        exp_t e;
        e.snap  = s;
        e.fs    = fs;
        e.hb    = hb;
        e.abort = abort;
        sb_q.push_back(e);
    endtask

    task automatic wait_pkts(input string tag, input int target, input bit done, input int budget);
        int n = 0;
        while (((done ? pkts_done : pkts_started) < target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, ((done ? pkts_done : pkts_started) >= target), 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (u_if.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, u_if.busy, 0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx"},   u_if.tx_int, 0);
        chk({tag, "_baud"}, u_if.baud_clk, 0);
        chk({tag, "_busy"}, u_if.busy, 0);
        chk({tag, "_snap"}, dut_snap(), 0);
        chk({tag, "_fs"},   u_if.frames_sent, 0);
        chk({tag, "_ow"},   u_if.overwrite_cnt, 0);
    endtask

    // Packet monitor: sampled on the falling clock edge, away from the DUT's active edge.
    logic tx_prev = 1'b0;
    logic baud_prev = 1'b0;
    int   hi_cycles = 0;
    int   lo_cycles = 0;
    bit   had_pkt = 1'b0;
    bit   stable_ok = 1'b1;

    always @(negedge clk) begin
        if (u_if.tx_int && !tx_prev) begin
            pkts_started++;
            chk("sb_nonempty", sb_q.size() != 0, 1);
            if (sb_q.size() != 0) begin
                cur = sb_q.pop_front();
                chk("pkt_snap", dut_snap(), cur.snap);
                chk("pkt_frames_sent", u_if.frames_sent, cur.fs);
                chk("rise_on_fall_ev", {baud_prev, u_if.baud_clk}, 2'b10);
                if (had_pkt) begin
                    if (cur.hb) chk("hb_gap_cycles", lo_cycles, (2 + HB) * BAUD);
                    else        chk("gap_min", lo_cycles >= 2 * BAUD, 1);
                end
            end
            hi_cycles = 1;
            stable_ok = 1'b1;
        end else if (u_if.tx_int) begin
            hi_cycles++;
            if (dut_snap() !== cur.snap || !u_if.busy) stable_ok = 1'b0;
        end else if (tx_prev) begin
            pkts_done++;
            if (cur.abort) begin
                had_pkt = 1'b0;
            end else begin
                chk("window_cycles", hi_cycles, FRAMES * BAUD);
                chk("snap_stable", stable_ok, 1);
                had_pkt = 1'b1;
            end
            lo_cycles = 1;
        end else begin
            lo_cycles++;
        end
        tx_prev   = u_if.tx_int;
        baud_prev = u_if.baud_clk;
    end

    initial begin
        u_if.frame_valid     = 1'b0;
        u_if.centre_pos_x_in = '0;
        u_if.centre_pos_y_in = '0;
        u_if.angle_x_in      = '0;
        u_if.angle_y_in      = '0;
        u_if.chieu_xoay_in   = 1'b0;

        #1;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single measurement.
        push_exp(mk(12'h3FC), 16'd1, 1'b0, 1'b0);
        drive_frame(mk(12'h3FC));
        wait_pkts("wait_pkt1_start", 1, 1'b0, 200);
        chk("pkt1_x", u_if.centre_pos_x, 12'h3FC);
        wait_pkts("wait_pkt1_done", 1, 1'b1, 1500);

        // Idle: heartbeat resend of the same snapshot.
        push_exp(mk(12'h3FC), 16'd2, 1'b1, 1'b0);
        wait_pkts("wait_hb_start", 2, 1'b0, 4000);

        // Three measurements during SEND: only the newest survives.
        repeat (10) @(negedge clk);
        drive_frame(mk(12'd1));
        @(negedge clk);
        drive_frame(mk(12'd2));
        @(negedge clk);
        drive_frame(mk(12'd3));
        chk("ow_after_burst3", u_if.overwrite_cnt, 8'd2);
        push_exp(mk(12'd3), 16'd3, 1'b0, 1'b0);
        wait_pkts("wait_pkt3_done", 3, 1'b1, 3000);
        wait_idle("idle_before_load", 100);

        // Second measurement lands in the LOAD cycle of the first.
        push_exp(mk(12'h0B5), 16'd4, 1'b0, 1'b0);
        push_exp(mk(12'h0C7), 16'd5, 1'b0, 1'b1);
        drive_frame(mk(12'h0B5));
        @(negedge clk);
        chk("busy_in_load", u_if.busy, 1);
        drive_frame(mk(12'h0C7));
        chk("ow_load_cycle", u_if.overwrite_cnt, 8'd2);
        wait_pkts("wait_pkt5_start", 5, 1'b0, 3000);

        // Reset deep inside SEND, between clock edges.
        repeat (60 * BAUD) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midsend_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        begin
            int n = 0;
            while (!u_if.baud_clk && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("first_toggle_cycles", n, DIV);
        end

        push_exp(mk(12'h0D1), 16'd1, 1'b0, 1'b0);
        drive_frame(mk(12'h0D1));
        wait_pkts("wait_pkt6_done", 6, 1'b1, 1500);
        wait_idle("idle_before_wrap", 100);

        // Counter wrap and overwrite saturation.
        @(negedge clk);
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent_q;
        @(negedge clk);
        chk("fs_preload", u_if.frames_sent, 16'hFFFF);
        push_exp(mk(12'h0E2), 16'd0, 1'b0, 1'b0);
        drive_frame(mk(12'h0E2));
        wait_pkts("wait_pkt7_start", 7, 1'b0, 200);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            drive_frame(mk(12'(i + 16)));
        end
        chk("ow_saturated", u_if.overwrite_cnt, 8'd255);
        push_exp(mk(12'd315), 16'd1, 1'b0, 1'b0);
        wait_pkts("wait_pkt8_done", 8, 1'b1, 3000);
        chk("sb_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter CLK_DIV_HALF, default 2604, system-clock cycles per half baud period; 50 MHz / 9600 baud.
REQ-002 Parameter FRAME_BITS, default 122, baud periods tx_int is held high per packet; 121 bit slots plus 1 for the registered output.
REQ-003 Parameter GAP_BITS, default 2, minimum baud periods tx_int is held low between packets.
REQ-004 Parameter HEARTBEAT_BITS, default 9600, idle baud periods after which the last snapshot is resent.
REQ-005 clk  in  1  system clock; all logic on posedge.
REQ-006 rst_n  in  1  reset; asynchronous, active-low.
REQ-007 frame_valid  in  1  one-cycle pulse: new measurement available.
REQ-008 centre_pos_x_in, centre_pos_y_in  in  12 each  measured centre.
REQ-009 angle_x_in, angle_y_in  in  10 each  measured angles.
REQ-010 chieu_xoay_in  in  1  rotation direction.
REQ-011 baud_clk  out  1  divided clock that drives the serializer clock.
REQ-012 tx_int  out  1  serializer enable window.
REQ-013 centre_pos_x, centre_pos_y (12), angle_x, angle_y (10), chieu_xoay (1)  out  snapshot fed to the serializer.
REQ-014 busy  out  1  high in states LOAD, SEND and GAP.
REQ-015 frames_sent  out  16  count of packets started; wraps at 0xFFFF->0.
REQ-016 overwrite_cnt  out  8  count of pending measurements replaced before being sent; saturates at 255.

Function
REQ-017 Baud divider: 12-bit counter counts 0..CLK_DIV_HALF-1; at terminal count it resets and baud_clk toggles.
REQ-018 fall_ev is the internal single-cycle flag set when baud_clk toggles 1->0; tx_int shall change only in the clk cycle of fall_ev.
REQ-019 Pending buffer: on frame_valid, latch all *_in fields into a one-deep pending register and set pend.
REQ-020 If pend is already set and a new frame_valid arrives, the newest data replaces the pending data and overwrite_cnt increments.
REQ-021 FSM states are IDLE, LOAD, SEND and GAP.
REQ-022 IDLE->LOAD: pend=1, or the heartbeat counter reaches HEARTBEAT_BITS-1 (counted on fall_ev).
REQ-023 LOAD: on pend=1, copy pending into the output snapshot and clear pend; on heartbeat, keep the existing snapshot.
REQ-024 LOAD->SEND: at the next fall_ev; tx_int goes 1, frames_sent increments, and the bit counter clears.
REQ-025 SEND: on each fall_ev the bit counter increments; at count FRAME_BITS-1, go to GAP with tx_int 0.
REQ-026 GAP: hold tx_int 0 for GAP_BITS fall_ev events, then go to IDLE.
REQ-027 Snapshot outputs shall change only in LOAD; they are constant whenever tx_int=1.
REQ-028 frame_valid and a pend clear in the same cycle (LOAD): LOAD takes the value pending before that cycle, and the new data sets pend again. This does not count as an overwrite.
REQ-029 The heartbeat counter clears on any frame_valid and on entry to IDLE; it counts only in IDLE.
REQ-030 frame_valid during SEND or GAP is buffered only; the packet in flight is not affected.

Reset
REQ-031 While rst_n=0, all of the following hold asynchronously:
- baud_clk=0, tx_int=0, busy=0;
- snapshot outputs=0, frames_sent=0, overwrite_cnt=0;
- pend=0, FSM=IDLE, all counters=0.
REQ-032 Reset asserted mid-SEND forces tx_int=0 immediately, so the serializer returns to idle-high.
REQ-033 After rst_n deasserts, the first baud_clk toggle occurs CLK_DIV_HALF cycles later.

Verification
REQ-034 Test parameters CLK_DIV_HALF=4, FRAME_BITS=122, GAP_BITS=2, HEARTBEAT_BITS=300.
- Stimulus: one frame_valid with x=0x3FC.
- Response: tx_int high for exactly 122 baud periods, rising on fall_ev; centre_pos_x=0x3FC throughout; frames_sent=1.
REQ-035 Three frame_valid pulses during SEND (x=1, 2, 3).
- Response: the next packet carries x=3; overwrite_cnt=2; tx_int is low for at least 2 baud periods between packets.
REQ-036 No frame_valid after the first packet.
- Response: a heartbeat resend starts 300 baud periods after IDLE entry, with an identical snapshot; frames_sent=2.
REQ-037 Reset pulse at bit 60 of SEND.
- Response: tx_int=0 and all outputs=0 with no clk edge; a subsequent frame_valid starts a fresh, full 122-period window.
REQ-038 Wrap and saturation: preload frames_sent=0xFFFF and force 300 overwrites.
- Response: frames_sent=0x0000 after the next packet; overwrite_cnt=255.
REQ-039 frame_valid in the LOAD cycle.
- Response: the old pending data is sent, the new data is sent next, and overwrite_cnt is unchanged.
